sdram_arbit: RTL



---
 rtl/sdram_pkg.sv | 24 ++
 rtl/sdram_arbit.sv | 134 +++++++++++++
 2 files changed

// File: rtl/sdram_pkg.sv
// Shared SDRAM definitions: command encodings, default widths and arbiter states.
package sdram_pkg;

   localparam int SDRAM_ADDR_W = 13;
   localparam int SDRAM_DATA_W = 16;

   // {cs_n, ras_n, cas_n, we_n}
   localparam logic [3:0] CMD_NOP       = 4'b0111;
   localparam logic [3:0] CMD_PRECHARGE = 4'b0010;
   localparam logic [3:0] CMD_AREF      = 4'b0001;
   localparam logic [3:0] CMD_ACTIVE    = 4'b0011;
   localparam logic [3:0] CMD_WRITE     = 4'b0100;
   localparam logic [3:0] CMD_READ      = 4'b0101;
   localparam logic [3:0] CMD_MREG      = 4'b0000;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_ARBIT = 3'd1,
      ST_AREF  = 3'd2,
      ST_WRITE = 3'd3,
      ST_READ  = 3'd4
   } arb_state_e;

endpackage

// File: rtl/sdram_arbit.sv
// SDRAM bus arbiter: grants init/refresh/write/read sources and muxes their commands onto the pins.
//
// state    | meaning
// ST_IDLE  | waiting for init_end, bus driven by the init source
// ST_ARBIT | NOP on bus, fixed priority aref > wr > rd picks next owner
// ST_AREF  | refresh owns the bus until aref_end
// ST_WRITE | burst write owns the bus until wr_end
// ST_READ  | burst read owns the bus until rd_end
module sdram_arbit
   import sdram_pkg::*;
#(
   parameter int ADDR_W = SDRAM_ADDR_W,
   parameter int DATA_W = SDRAM_DATA_W
) (
   input  logic              sys_clk,
   input  logic              sys_rst,
   input  logic              init_end,
   input  logic [3:0]        init_cmd,
   input  logic [1:0]        init_ba,
   input  logic [ADDR_W-1:0] init_addr,
   input  logic              aref_req,
   input  logic              aref_end,
   input  logic [3:0]        aref_cmd,
   input  logic [1:0]        aref_ba,
   input  logic [ADDR_W-1:0] aref_addr,
   input  logic              wr_req,
   input  logic              wr_end,
   input  logic [3:0]        wr_cmd,
   input  logic [1:0]        wr_ba,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic              wr_sdram_en,
   input  logic [DATA_W-1:0] wr_sdram_data,
   input  logic              rd_req,
   input  logic              rd_end,
   input  logic [3:0]        rd_cmd,
   input  logic [1:0]        rd_ba,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic              aref_en,
   output logic              wr_en,
   output logic              rd_en,
   output logic              sdram_cke,
   output logic              sdram_cs_n,
   output logic              sdram_ras_n,
   output logic              sdram_cas_n,
   output logic              sdram_we_n,
   output logic [1:0]        sdram_ba,
   output logic [ADDR_W-1:0] sdram_addr,
   output logic [DATA_W-1:0] sdram_dq_o,
   output logic              sdram_dq_oe
);

   arb_state_e state_q, state_d;
   logic       aref_en_q, aref_en_d;
   logic       wr_en_q, wr_en_d;
   logic       rd_en_q, rd_en_d;

   logic [3:0]        cmd_mux;
   logic [1:0]        ba_mux;
   logic [ADDR_W-1:0] addr_mux;

   // Every grant passes back through ARBIT, which guarantees a NOP cycle between owners.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE:  if (init_end) state_d = ST_ARBIT;
         ST_ARBIT: begin
            if (aref_req)    state_d = ST_AREF;
            else if (wr_req) state_d = ST_WRITE;
            else if (rd_req) state_d = ST_READ;
         end
         ST_AREF:  if (aref_end) state_d = ST_ARBIT;
         ST_WRITE: if (wr_end)   state_d = ST_ARBIT;
         ST_READ:  if (rd_end)   state_d = ST_ARBIT;
         default:  state_d = ST_IDLE;
      endcase
      aref_en_d = (state_d == ST_AREF);
      wr_en_d   = (state_d == ST_WRITE);
      rd_en_d   = (state_d == ST_READ);
   end

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         state_q   <= ST_IDLE;
         aref_en_q <= 1'b0;
         wr_en_q   <= 1'b0;
         rd_en_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         aref_en_q <= aref_en_d;
         wr_en_q   <= wr_en_d;
         rd_en_q   <= rd_en_d;
      end
   end

   always_comb begin
      cmd_mux  = CMD_NOP;
      ba_mux   = 2'b11;
      addr_mux = '1;
      unique case (state_q)
         ST_IDLE: begin
            cmd_mux  = init_cmd;
            ba_mux   = init_ba;
            addr_mux = init_addr;
         end
         ST_AREF: begin
            cmd_mux  = aref_cmd;
            ba_mux   = aref_ba;
            addr_mux = aref_addr;
         end
         ST_WRITE: begin
            cmd_mux  = wr_cmd;
            ba_mux   = wr_ba;
            addr_mux = wr_addr;
         end
         ST_READ: begin
            cmd_mux  = rd_cmd;
            ba_mux   = rd_ba;
            addr_mux = rd_addr;
         end
         default: ;
      endcase
   end

   assign aref_en     = aref_en_q;
   assign wr_en       = wr_en_q;
   assign rd_en       = rd_en_q;
   assign sdram_cke   = 1'b1;
   assign {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} = cmd_mux;
   assign sdram_ba    = ba_mux;
   assign sdram_addr  = addr_mux;
   assign sdram_dq_oe = wr_sdram_en & (state_q == ST_WRITE);
   assign sdram_dq_o  = sdram_dq_oe ? wr_sdram_data : '0;

endmodule
